// File: rtl/dmem_access_if.sv
// Requester / data-memory bundle for dmem_access_unit.
// The slave side is the access unit. The master side holds the MEM-stage requester and dmem.
interface dmem_access_if #(
    parameter int AW = 6
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [1:0]      req_size;
    logic            req_sext;
    logic [AW+1:0]   req_addr;
    logic [31:0]     req_wdata;
    logic            rsp_valid;
    logic [31:0]     rsp_rdata;
    logic            rsp_err;
    logic            mem_wr;
    logic [AW-1:0]   mem_addr;
    logic [31:0]     mem_din;
    logic [31:0]     mem_dout;

    modport slave (
        input  req_valid, req_we, req_size, req_sext, req_addr, req_wdata, mem_dout,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_wr, mem_addr, mem_din
    );

    modport master (
        output req_valid, req_we, req_size, req_sext, req_addr, req_wdata, mem_dout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_wr, mem_addr, mem_din
    );
endinterface

// File: rtl/dmem_access_unit.sv
// Single-outstanding load/store controller for the word-wide data memory.
// Define DMEM_SUBWORD_EN for byte/half access. Sub-word stores are done as read-modify-write.
module dmem_access_unit #(
    parameter int AW = 6,
    parameter int DW = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    dmem_access_if.slave bus
);
`ifdef DMEM_SUBWORD_EN
    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
`endif

    typedef struct packed {
        logic        we;
        logic        err;
`ifdef DMEM_SUBWORD_EN
        logic [1:0]  size;
        logic        sext;
        logic [1:0]  lane;
        logic [15:0] wdata;
`endif
    } req_t;

    state_t        state_q, state_d;
    req_t          rq;
    logic          accept;
    logic          in_err;
    logic          in_word_st;
    logic [DW-1:0] ld_data;

    assign accept        = bus.req_valid && (state_q == IDLE);
    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign in_word_st    = bus.req_we && (bus.req_size == 2'b10);

`ifdef DMEM_SUBWORD_EN
    logic          rmw;
    logic [DW-1:0] mg_data;
    logic [7:0]    b_lane;
    logic [15:0]   h_lane;

    assign in_err = (bus.req_size == 2'b11)
                 || ((bus.req_size == 2'b01) && bus.req_addr[0])
                 || ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    assign rmw    = rq.we && !rq.err && (rq.size != 2'b10);

    // Lane extraction for loads and lane merge for RMW, both from the live dout
    always_comb begin
        b_lane  = bus.mem_dout[{rq.lane, 3'b000} +: 8];
        h_lane  = bus.mem_dout[{rq.lane[1], 4'b0000} +: 16];
        mg_data = bus.mem_dout;
        if (rq.size == 2'b00)
            mg_data[{rq.lane, 3'b000} +: 8] = rq.wdata[7:0];
        else
            mg_data[{rq.lane[1], 4'b0000} +: 16] = rq.wdata;
        case (rq.size)
            2'b00:   ld_data = {{24{rq.sext & b_lane[7]}}, b_lane};
            2'b01:   ld_data = {{16{rq.sext & h_lane[15]}}, h_lane};
            default: ld_data = bus.mem_dout;
        endcase
    end
`else
    logic unused_sext;

    assign in_err      = (bus.req_size != 2'b10) || (bus.req_addr[1:0] != 2'b00);
    assign ld_data     = bus.mem_dout;
    assign unused_sext = bus.req_sext;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ACCESS;
            ACCESS: begin
                state_d = RESP;
`ifdef DMEM_SUBWORD_EN
                if (rmw) state_d = WRITE;
`endif
            end
`ifdef DMEM_SUBWORD_EN
            WRITE:   state_d = RESP;
`endif
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq            <= '0;
            bus.mem_wr    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_din   <= '0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    rq.we  <= bus.req_we;
                    rq.err <= in_err;
`ifdef DMEM_SUBWORD_EN
                    rq.size  <= bus.req_size;
                    rq.sext  <= bus.req_sext;
                    rq.lane  <= bus.req_addr[1:0];
                    rq.wdata <= bus.req_wdata[15:0];
`endif
                    // Rejected requests never touch the memory port
                    if (!in_err) begin
                        bus.mem_addr <= bus.req_addr[AW+1:2];
                        if (in_word_st) begin
                            bus.mem_din <= bus.req_wdata;
                            bus.mem_wr  <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    bus.mem_wr <= 1'b0;
`ifdef DMEM_SUBWORD_EN
                    if (rmw) begin
                        bus.mem_din <= mg_data;
                        bus.mem_wr  <= 1'b1;
                    end else
`endif
                    begin
                        bus.rsp_err   <= rq.err;
                        bus.rsp_rdata <= (rq.err || rq.we) ? '0 : ld_data;
                    end
                end
`ifdef DMEM_SUBWORD_EN
                WRITE: begin
                    bus.mem_wr    <= 1'b0;
                    bus.rsp_err   <= 1'b0;
                    bus.rsp_rdata <= '0;
                end
`endif
                default: ;
            endcase
        end
    end
endmodule
